// File: rtl/pulse_sequencer_if.sv
// Descriptor FIFO read port, pulse-memory read port and sample output stream
// of the pulse sequencer, bundled for connection as one port.
interface pulse_sequencer_if #(
   parameter int unsigned TSTART_W = 32,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned WORD_W   = 32
);
   logic                fifo_empty;
   logic [TSTART_W-1:0] fifo_delay;
   logic [ADDR_W-1:0]   fifo_addr;
   logic                fifo_rd_en;
   logic                pmem_en;
   logic [ADDR_W-1:0]   pmem_addr;
   logic [WORD_W-1:0]   pmem_rdata;
   logic                sample_valid;
   logic [WORD_W-1:0]   sample_data;
   logic                pulse_start;
   logic                pulse_done;

   modport master (
      input  fifo_empty, fifo_delay, fifo_addr, pmem_rdata,
      output fifo_rd_en, pmem_en, pmem_addr,
      output sample_valid, sample_data, pulse_start, pulse_done
   );

   modport slave (
      output fifo_empty, fifo_delay, fifo_addr, pmem_rdata,
      input  fifo_rd_en, pmem_en, pmem_addr,
      input  sample_valid, sample_data, pulse_start, pulse_done
   );
endinterface

// File: rtl/pulse_sequencer.sv
// Pops {delay, base} descriptors, waits, reads the envelope header then streams
// N samples. Define PULSE_SEQ_ABS_TIME_EN to treat delay as an absolute timestamp.
module pulse_sequencer #(
   parameter int unsigned TSTART_W = 32,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned LEN_W    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   pulse_sequencer_if.master   bus,
   output logic                busy,
   output logic [TSTART_W-1:0] timestamp,
   output logic                late_error
);

   typedef enum logic [1:0] {IDLE, WAIT, HDR, PLAY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    remain_q;
   logic                rd_smp_q, rd_first_q, rd_last_q;

   logic                pop, hdr_rd, smp_rd, smp_first, smp_last, zero_len, wait_done;
   logic [ADDR_W-1:0]   rd_addr;
   logic [LEN_W-1:0]    hdr_len;

`ifdef PULSE_SEQ_ABS_TIME_EN
   logic [TSTART_W-1:0] target_q;
   logic [TSTART_W-1:0] lead;
   logic                early_q;

   assign lead      = bus.fifo_delay - timestamp;
   assign wait_done = (timestamp == target_q) || early_q;
`else
   logic [TSTART_W-1:0] cnt_q;

   assign wait_done  = (cnt_q == '0);
   assign late_error = 1'b0;
`endif

   assign hdr_len = bus.pmem_rdata[LEN_W-1:0];

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      hdr_rd    = 1'b0;
      smp_rd    = 1'b0;
      smp_first = 1'b0;
      smp_last  = 1'b0;
      zero_len  = 1'b0;
      rd_addr   = '0;
      unique case (state_q)
         IDLE: begin
            if (!bus.fifo_empty) begin
               pop     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_done) begin
               hdr_rd  = 1'b1;
               rd_addr = base_q;
               state_d = HDR;
            end
         end
         HDR: begin
            if (hdr_len == '0) begin
               zero_len = 1'b1;
               state_d  = IDLE;
            end else begin
               smp_rd    = 1'b1;
               smp_first = 1'b1;
               smp_last  = (hdr_len == LEN_W'(1));
               rd_addr   = base_q + ADDR_W'(1);
               state_d   = smp_last ? IDLE : PLAY;
            end
         end
         PLAY: begin
            smp_rd   = 1'b1;
            smp_last = (remain_q == LEN_W'(1));
            rd_addr  = addr_q;
            if (smp_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pop strobe is combinational from IDLE; gate it so reset forces it low at once.
   assign bus.fifo_rd_en = pop & reset_n;
   assign bus.pmem_en    = hdr_rd | smp_rd;
   assign bus.pmem_addr  = rd_addr;
   assign busy = (state_q != IDLE) | rd_smp_q | bus.sample_valid | bus.pulse_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         base_q           <= '0;
         addr_q           <= '0;
         remain_q         <= '0;
         rd_smp_q         <= 1'b0;
         rd_first_q       <= 1'b0;
         rd_last_q        <= 1'b0;
         timestamp        <= '0;
         bus.sample_valid <= 1'b0;
         bus.sample_data  <= '0;
         bus.pulse_start  <= 1'b0;
         bus.pulse_done   <= 1'b0;
`ifdef PULSE_SEQ_ABS_TIME_EN
         target_q         <= '0;
         early_q          <= 1'b0;
         late_error       <= 1'b0;
`else
         cnt_q            <= '0;
`endif
      end else begin
         state_q   <= state_d;
         timestamp <= timestamp + TSTART_W'(1);
         if (pop) begin
            base_q <= bus.fifo_addr;
`ifdef PULSE_SEQ_ABS_TIME_EN
            target_q <= bus.fifo_delay;
            // A target equal to the pop timestamp can no longer be hit, so leave on the first WAIT cycle.
            early_q  <= lead[TSTART_W-1] || (lead == '0);
            if (lead[TSTART_W-1]) late_error <= 1'b1;
`else
            cnt_q  <= bus.fifo_delay;
`endif
         end
`ifndef PULSE_SEQ_ABS_TIME_EN
         if (state_q == WAIT && !wait_done) cnt_q <= cnt_q - TSTART_W'(1);
`endif
         if (smp_rd) begin
            addr_q   <= rd_addr + ADDR_W'(1);
            remain_q <= (state_q == HDR) ? hdr_len - LEN_W'(1) : remain_q - LEN_W'(1);
         end
         rd_smp_q         <= smp_rd;
         rd_first_q       <= smp_first;
         rd_last_q        <= smp_last;
         bus.sample_valid <= rd_smp_q;
         bus.sample_data  <= rd_smp_q ? bus.pmem_rdata : '0;
         bus.pulse_start  <= rd_first_q;
         bus.pulse_done   <= rd_last_q | zero_len;
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: FIFO and pulse-memory models, expected
// samples queued at descriptor push and compared as the sample stream appears.
module tb_pulse_sequencer;
   localparam int unsigned TSTART_W = 32;
   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned LEN_W    = 16;

   typedef struct {
      logic [TSTART_W-1:0] delay;
      logic [ADDR_W-1:0]   addr;
   } desc_t;

   typedef struct {
      logic [WORD_W-1:0] data;
      int                cyc;
      logic              first;
      logic              last;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                busy;
   logic [TSTART_W-1:0] timestamp;
   logic                late_error;

   logic [WORD_W-1:0]   mem [256];
   desc_t               fq[$];
   exp_t                sb[$];
   logic [ADDR_W-1:0]   rd_log[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int pop_count = 0;
   int bad_pops = 0;
   int done_count = 0;

   pulse_sequencer_if #(.TSTART_W(TSTART_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

   pulse_sequencer #(
      .TSTART_W(TSTART_W), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .busy(busy),
      .timestamp(timestamp),
      .late_error(late_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.pmem_en) bus.pmem_rdata <= mem[bus.pmem_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic update_fifo();
      if (fq.size() != 0) begin
         bus.fifo_empty = 1'b0;
         bus.fifo_delay = fq[0].delay;
         bus.fifo_addr  = fq[0].addr;
      end else begin
         bus.fifo_empty = 1'b1;
         bus.fifo_delay = '0;
         bus.fifo_addr  = '0;
      end
   endtask

   task automatic push(input logic [TSTART_W-1:0] d, input logic [ADDR_W-1:0] a);
      desc_t x;
      x.delay = d;
      x.addr  = a;
      fq.push_back(x);
      update_fifo();
   endtask

   task automatic expect_pulse(input logic [ADDR_W-1:0] base, input int n, input int first_cyc);
      exp_t e;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < n; i++) begin
         a       = base + ADDR_W'(1) + ADDR_W'(i);
         e.data  = mem[a];
         e.cyc   = first_cyc + i;
         e.first = (i == 0);
         e.last  = (i == n - 1);
         sb.push_back(e);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (bus.sample_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_sample", 64'(bus.sample_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("sample_data", 64'(bus.sample_data), 64'(e.data));
            check("sample_cycle", 64'(cyc), 64'(e.cyc));
            check("pulse_start", 64'(bus.pulse_start), 64'(e.first));
            check("pulse_done", 64'(bus.pulse_done), 64'(e.last));
         end
      end else begin
         check("start_without_sample", 64'(bus.pulse_start), 64'd0);
      end
      if (bus.pulse_done) done_count++;
   endtask

   // One clock: observe at negedge, pop the FIFO model just after posedge,
   // return at posedge+3 where directed stimulus is applied.
   task automatic step();
      logic p;
      @(negedge clk);
      monitor();
      p = bus.fifo_rd_en;
      if (bus.pmem_en) rd_log.push_back(bus.pmem_addr);
      @(posedge clk);
      cyc++;
      #1;
      if (p) begin
         pop_count++;
         if (fq.size() == 0) bad_pops++;
         else void'(fq.pop_front());
         update_fifo();
      end
      #2;
   endtask

   task automatic goto(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      int c, d0, p0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hBAD0_0000 | 32'(i);
      mem[8'h10] = 32'd3;
      mem[8'h11] = 32'hA;
      mem[8'h12] = 32'hB;
      mem[8'h13] = 32'hC;
      mem[8'h30] = 32'hDEAD_0000;
      mem[8'hFE] = 32'd3;
      mem[8'hFF] = 32'h1111_00FF;
      mem[8'h00] = 32'h2222_0000;
      mem[8'h01] = 32'h3333_0001;
      mem[8'h20] = 32'd1;
      mem[8'h21] = 32'h55;
      mem[8'h40] = 32'd8;
      for (int i = 1; i <= 8; i++) mem[8'h40 + i] = 32'h400 + 32'(i);
      update_fifo();

      // reset state
      step();
      step();
      check("rst_sample_valid", 64'(bus.sample_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_timestamp", 64'(timestamp), 64'd0);
      check("rst_pmem_en", 64'(bus.pmem_en), 64'd0);
      reset_n = 1'b1;
      rel_cyc = cyc;
      step();
      step();
      check("timestamp_run", 64'(timestamp), 64'(cyc - rel_cyc));

      // delay 0, N=3
      step();
      c = cyc; d0 = done_count; p0 = pop_count;
      push(32'd0, 8'h10);
      expect_pulse(8'h10, 3, c + 4);
      goto(c + 6);
      check("t1_busy_at_done", 64'(busy), 64'd1);
      goto(c + 7);
      check("t1_busy_after", 64'(busy), 64'd0);
      check("t1_done_count", 64'(done_count), 64'(d0 + 1));
      check("t1_pop_count", 64'(pop_count), 64'(p0 + 1));
      check("t1_sb_empty", 64'(sb.size()), 64'd0);

      // delay 5, same pulse
      step();
      c = cyc; d0 = done_count; p0 = pop_count;
      push(32'd5, 8'h10);
      expect_pulse(8'h10, 3, c + 9);
      goto(c + 13);
      check("t2_pop_count", 64'(pop_count), 64'(p0 + 1));
      check("t2_done_count", 64'(done_count), 64'(d0 + 1));
      check("t2_sb_empty", 64'(sb.size()), 64'd0);
      check("t2_busy", 64'(busy), 64'd0);

      // N=0 with delay 2, next descriptor popped straight after
      step();
      c = cyc; d0 = done_count; p0 = pop_count;
      push(32'd2, 8'h30);
      push(32'd0, 8'h20);
      expect_pulse(8'h20, 1, c + 9);
      goto(c + 4);
      check("t3_done_early", 64'(bus.pulse_done), 64'd0);
      goto(c + 5);
      check("t3_done_n0", 64'(bus.pulse_done), 64'd1);
      check("t3_valid_n0", 64'(bus.sample_valid), 64'd0);
      check("t3_second_pop", 64'(bus.fifo_rd_en), 64'd1);
      goto(c + 12);
      check("t3_pop_count", 64'(pop_count), 64'(p0 + 2));
      check("t3_done_count", 64'(done_count), 64'(d0 + 2));
      check("t3_sb_empty", 64'(sb.size()), 64'd0);

      // back-to-back with address wrap
      step();
      rd_log.delete();
      c = cyc; d0 = done_count;
      push(32'd0, 8'hFE);
      push(32'd0, 8'h20);
      expect_pulse(8'hFE, 3, c + 4);
      expect_pulse(8'h20, 1, c + 9);
      goto(c + 12);
      check("t4_rd_count", 64'(rd_log.size()), 64'd6);
      if (rd_log.size() == 6) begin
         check("t4_rd0", 64'(rd_log[0]), 64'hFE);
         check("t4_rd1", 64'(rd_log[1]), 64'hFF);
         check("t4_rd2", 64'(rd_log[2]), 64'h00);
         check("t4_rd3", 64'(rd_log[3]), 64'h01);
         check("t4_rd4", 64'(rd_log[4]), 64'h20);
         check("t4_rd5", 64'(rd_log[5]), 64'h21);
      end
      check("t4_done_count", 64'(done_count), 64'(d0 + 2));
      check("t4_sb_empty", 64'(sb.size()), 64'd0);

      // reset during the second sample of an N=8 pulse
      step();
      c = cyc; d0 = done_count;
      push(32'd0, 8'h40);
      expect_pulse(8'h40, 8, c + 4);
      goto(c + 5);
      reset_n = 1'b0;
      #1;
      sb.delete();
      check("t5_sample_valid", 64'(bus.sample_valid), 64'd0);
      check("t5_sample_data", 64'(bus.sample_data), 64'd0);
      check("t5_pulse_start", 64'(bus.pulse_start), 64'd0);
      check("t5_pulse_done", 64'(bus.pulse_done), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_pmem_en", 64'(bus.pmem_en), 64'd0);
      check("t5_pmem_addr", 64'(bus.pmem_addr), 64'd0);
      check("t5_fifo_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("t5_timestamp", 64'(timestamp), 64'd0);
      p0 = pop_count;
      step();
      step();
      reset_n = 1'b1;
      rel_cyc = cyc;
      goto(cyc + 12);
      check("t5_no_pop", 64'(pop_count), 64'(p0));
      check("t5_no_done", 64'(done_count), 64'(d0));
      check("t5_busy_after", 64'(busy), 64'd0);
      check("t5_timestamp_run", 64'(timestamp), 64'(cyc - rel_cyc));

      check("late_error", 64'(late_error), 64'd0);
      check("bad_pops", 64'(bad_pops), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Consumer end of the core's pulse-descriptor channel.
- Pops descriptors {delay, pulse_mem_addr} from the read port of the pulse async FIFO, waits the programmed delay, then fetches the pulse envelope from pulse memory.
- Streams the envelope samples, one per cycle, to the DAC/output path.
- Runs entirely in the pulse clock domain on the FIFO read side; the FIFO owns all clock-domain crossing.

Parameters:
- TSTART_W, 32, width of descriptor delay field and of the timestamp counter
- ADDR_W, 8, pulse memory address width (descriptor pulse_mem_addr width)
- WORD_W, 32, pulse memory word and sample width
- LEN_W, 16, sample-count field width in the header word (LEN_W <= WORD_W)

Ports:
- clk  in  1  pulse-domain clock
- reset_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  descriptor FIFO empty (first-word-fall-through read port)
- fifo_delay  in  TSTART_W  head descriptor delay field, valid when !fifo_empty
- fifo_addr  in  ADDR_W  head descriptor pulse_mem_addr, valid when !fifo_empty
- fifo_rd_en  out  1  pop strobe, one cycle per descriptor
- pmem_en  out  1  pulse memory read enable
- pmem_addr  out  ADDR_W  pulse memory read address
- pmem_rdata  in  WORD_W  read data, valid exactly 1 cycle after pmem_en
- sample_valid  out  1  sample_data valid this cycle
- sample_data  out  WORD_W  envelope sample (registered)
- pulse_start  out  1  1-cycle strobe coincident with first sample
- pulse_done  out  1  1-cycle strobe coincident with last sample (or header, if N=0)
- busy  out  1  high in any state other than IDLE, or while output pipeline is non-empty
- timestamp  out  TSTART_W  free-running cycle counter, wraps modulo 2^TSTART_W
- late_error  out  1  sticky; only meaningful with optional feature, else tied 0

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; timestamp=0; internal counters cleared; any pulse in flight is abandoned without pulse_done; the popped descriptor is discarded.
- Memory format: word[base] is the header, N = header[LEN_W-1:0]. Samples occupy base+1 .. base+N. Addresses increment modulo 2^ADDR_W (wrap 0xFF->0x00 at default width).
- FSM states: IDLE, WAIT, HDR, PLAY.
- IDLE: when !fifo_empty, assert fifo_rd_en for 1 cycle, latch fifo_delay/fifo_addr, load delay counter, go to WAIT. fifo_rd_en is never asserted when fifo_empty=1.
- WAIT: if counter==0, issue header read (pmem_en=1, pmem_addr=base) and go to HDR; else decrement. Delay D therefore adds exactly D cycles.
- HDR: latch N from pmem_rdata.
  - If N==0: pulse_done asserted on the next cycle, no samples; go to IDLE.
  - Else: issue read base+1; go to PLAY.
- PLAY: issue reads base+2 .. base+N back-to-back; go to IDLE in the cycle after the base+N read is issued.
- Sample path: sample_data/sample_valid are pmem_rdata registered once. First sample appears at pop cycle + D + 4, then N consecutive valid cycles with no bubbles.
- Back-to-back pulses: IDLE may pop in its first cycle, so consecutive D=0 pulses show exactly 2 invalid cycles between the previous pulse_done and the next pulse_start.
- N maximum 2^LEN_W-1. If N >= 2^ADDR_W, reads wrap through the header region; this is legal and not flagged.
- timestamp increments every cycle from reset release, independent of FSM state.

Optional Feature:
- Macro PULSE_SEQ_ABS_TIME_EN.
- Defined:
  - Descriptor delay is an absolute timestamp. WAIT leaves when timestamp == delay; the header read is issued that cycle.
  - If at the pop cycle (delay - timestamp) modulo 2^TSTART_W >= 2^(TSTART_W-1), the target is in the past: set late_error (sticky until reset) and issue the header read on the first WAIT cycle.
- Undefined: relative delay as above; late_error tied 0.

Test Plan:
- delay=0, base=0x10, mem[0x10]=3, samples 0xA,0xB,0xC, pop at cycle 0 -> samples 0xA/0xB/0xC valid at cycles 4/5/6; pulse_start@4; pulse_done@6; busy low @7.
- delay=5, same pulse -> first sample at cycle 9, three contiguous samples; fifo_rd_en exactly one cycle.
- header N=0 with delay=2 -> sample_valid never high; pulse_done at cycle 5; FSM returns to IDLE and pops the next descriptor if present.
- two queued descriptors, base=0xFE N=3 then base=0x20 N=1 -> reads 0xFF,0x00,0x01 then 0x20,0x21; exactly 2 invalid cycles between first pulse_done and second pulse_start.
- reset_n driven low during 2nd sample of an N=8 pulse -> all outputs 0 immediately, no pulse_done; after release with FIFO empty, fifo_rd_en stays 0.
- PULSE_SEQ_ABS_TIME_EN: pop at timestamp=100 with delay=50 -> late_error=1 and header read issued next cycle; delay=200 -> header read issued when timestamp=200, late_error stays 0.
